// File: rtl/ws2812b_pkg.sv
// Shared constants, types and helpers for the WS2812B meter path.
package ws2812b_pkg;

  localparam int unsigned COUNT_W = 32;
  localparam int unsigned COLOR_N = 3;

  // Colour slot indices into the per-colour count vector.
  localparam logic [1:0] COLOR_GREEN  = 2'd0;
  localparam logic [1:0] COLOR_YELLOW = 2'd1;
  localparam logic [1:0] COLOR_RED    = 2'd2;

  // Default zone colours as GRB words, matching the meter controller.
  localparam logic [23:0] DEFAULT_GRB_GREEN  = 24'hFF_00_00;
  localparam logic [23:0] DEFAULT_GRB_YELLOW = 24'hFF_FF_00;
  localparam logic [23:0] DEFAULT_GRB_RED    = 24'h00_FF_00;

  // One LED count per colour slot.
  typedef logic [COLOR_N-1:0][COUNT_W-1:0] counts_t;

  function automatic logic [COUNT_W-1:0] umin(input logic [COUNT_W-1:0] a,
                                              input logic [COUNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [COUNT_W-1:0] sat_sub(input logic [COUNT_W-1:0] a,
                                                 input logic [COUNT_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/ws2812b_peak_window.sv
// Sample magnitude and per-window peak tracker with a one-cycle done pulse.
module ws2812b_peak_window
  import ws2812b_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned WINDOW   = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       is_enable,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic                       sample_valid,
  output logic                       done,
  output logic        [SAMPLE_W-2:0] peak
);

  localparam int unsigned MAG_W = SAMPLE_W - 1;
  localparam int unsigned CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  logic [SAMPLE_W-1:0] neg_c;
  logic [MAG_W-1:0]    mag_c;
  logic [MAG_W-1:0]    peak_c;
  logic [MAG_W-1:0]    win_peak;
  logic [CNT_W-1:0]    win_cnt;

  // Absolute value; the most negative code saturates to the largest positive one.
  always_comb begin
    neg_c = SAMPLE_W'(-sample);
    mag_c = sample[MAG_W-1:0];
    if (sample[SAMPLE_W-1]) begin
      if (sample[MAG_W-1:0] == '0) mag_c = '1;
      else                         mag_c = neg_c[MAG_W-1:0];
    end
    peak_c = (mag_c > win_peak) ? mag_c : win_peak;
  end

  // Window accumulation; the last sample closes the window and restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt  <= '0;
      win_peak <= '0;
      done     <= 1'b0;
      peak     <= '0;
    end else begin
      done <= 1'b0;
      if (!is_enable) begin
        win_cnt  <= '0;
        win_peak <= '0;
      end else if (sample_valid) begin
        if (win_cnt == CNT_LAST) begin
          win_cnt  <= '0;
          win_peak <= '0;
          done     <= 1'b1;
          peak     <= peak_c;
        end else begin
          win_cnt  <= win_cnt + CNT_W'(1);
          win_peak <= peak_c;
        end
      end
    end
  end

endmodule

// File: rtl/ws2812b_level_mapper.sv
// Audio peak meter front end: window peak -> LED level -> green/yellow/red counts.
module ws2812b_level_mapper
  import ws2812b_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = 16,
  parameter int unsigned WINDOW      = 1024,
  parameter int unsigned DECAY_TICKS = 1000000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       is_enable,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic                       sample_valid,
  input  logic        [COUNT_W-1:0]  max_count,
  input  logic        [COUNT_W-1:0]  green_limit,
  input  logic        [COUNT_W-1:0]  yellow_limit,
  output logic        [COUNT_W-1:0]  count_green,
  output logic        [COUNT_W-1:0]  count_yellow,
  output logic        [COUNT_W-1:0]  count_red,
  output logic                       counts_valid
);

  localparam int unsigned MAG_W  = SAMPLE_W - 1;
  localparam int unsigned PROD_W = COUNT_W + MAG_W;
  localparam int unsigned TICK_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DECAY_TICKS - 1);

  logic               done;
  logic [MAG_W-1:0]   peak;
  logic [PROD_W-1:0]  prod_c;
  logic [PROD_W-1:0]  shifted_c;
  logic [COUNT_W-1:0] target_c;
  logic [COUNT_W-1:0] target;
  logic               target_new;
  logic [TICK_W-1:0]  tick_cnt;
  logic               tick_c;
  logic [COUNT_W-1:0] level;
  logic [COUNT_W-1:0] decayed_c;
  logic [COUNT_W-1:0] attack_c;
  logic [COUNT_W-1:0] level_next_c;
  logic [COUNT_W-1:0] yellow_top_c;
  counts_t            split_c;
  counts_t            counts;

  ws2812b_peak_window #(
    .SAMPLE_W (SAMPLE_W),
    .WINDOW   (WINDOW)
  ) u_peak_window (
    .clk          (clk),
    .reset_n      (reset_n),
    .is_enable    (is_enable),
    .sample       (sample),
    .sample_valid (sample_valid),
    .done         (done),
    .peak         (peak)
  );

  // Peak scaled to LEDs with a full-width product, clamped to the strip length.
  always_comb begin
    prod_c    = PROD_W'(peak) * PROD_W'(max_count);
    shifted_c = prod_c >> MAG_W;
    target_c  = (shifted_c > PROD_W'(max_count)) ? max_count : shifted_c[COUNT_W-1:0];
  end

  // Target register with a one-cycle freshness flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target     <= '0;
      target_new <= 1'b0;
    end else begin
      target_new <= done;
      if (done) target <= target_c;
    end
  end

  assign tick_c = (tick_cnt == TICK_LAST);

  // Free-running release timer, parked at zero while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        tick_cnt <= '0;
    else if (!is_enable) tick_cnt <= '0;
    else if (tick_c)     tick_cnt <= '0;
    else                 tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // Instant attack, one-LED release per tick; attack wins a coincident tick.
  always_comb begin
    decayed_c = level;
    if (tick_c && (level != '0)) decayed_c = level - COUNT_W'(1);
    attack_c = decayed_c;
    if (target_new && (target > decayed_c)) attack_c = target;
    level_next_c = umin(attack_c, max_count);
    if (!is_enable) level_next_c = '0;
  end

  // Held meter level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) level <= '0;
    else          level <= level_next_c;
  end

  // Colour split; saturating subtraction keeps an inverted yellow zone empty.
  always_comb begin
    split_c               = '0;
    split_c[COLOR_GREEN]  = umin(level, green_limit);
    yellow_top_c          = umin(level, yellow_limit);
    split_c[COLOR_YELLOW] = sat_sub(yellow_top_c, split_c[COLOR_GREEN]);
    split_c[COLOR_RED]    = level - split_c[COLOR_GREEN] - split_c[COLOR_YELLOW];
  end

  // Registered counts, with a strobe only when they actually change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counts       <= '0;
      counts_valid <= 1'b0;
    end else begin
      counts       <= split_c;
      counts_valid <= (split_c != counts);
    end
  end

  assign count_green  = counts[COLOR_GREEN];
  assign count_yellow = counts[COLOR_YELLOW];
  assign count_red    = counts[COLOR_RED];

endmodule

// File: tb/tb_ws2812b_level_mapper.sv
// Scenario bench for ws2812b_level_mapper with an expected-counts queue.
module tb_ws2812b_level_mapper;

  localparam int unsigned SW  = 16;
  localparam int unsigned WIN = 4;
  localparam int unsigned DT  = 8;

  typedef struct packed {
    logic [31:0] g;
    logic [31:0] y;
    logic [31:0] r;
  } exp_t;

  logic               clk          = 1'b0;
  logic               reset_n      = 1'b1;
  logic               is_enable    = 1'b0;
  logic signed [SW-1:0] sample     = '0;
  logic               sample_valid = 1'b0;
  logic [31:0]        max_count    = 32'd60;
  logic [31:0]        green_limit  = 32'd40;
  logic [31:0]        yellow_limit = 32'd50;
  logic [31:0]        count_green;
  logic [31:0]        count_yellow;
  logic [31:0]        count_red;
  logic               counts_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned ecnt = 0;
  exp_t sb[$];

  ws2812b_level_mapper #(
    .SAMPLE_W    (SW),
    .WINDOW      (WIN),
    .DECAY_TICKS (DT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .is_enable    (is_enable),
    .sample       (sample),
    .sample_valid (sample_valid),
    .max_count    (max_count),
    .green_limit  (green_limit),
    .yellow_limit (yellow_limit),
    .count_green  (count_green),
    .count_yellow (count_yellow),
    .count_red    (count_red),
    .counts_valid (counts_valid)
  );

  always #5 clk = ~clk;

  // Release-timer phase as the bench expects it: enabled clock edges since reset/enable.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)        ecnt <= 0;
    else if (!is_enable) ecnt <= 0;
    else                 ecnt <= ecnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic exp_t split(input logic [31:0] lvl, input logic [31:0] gl,
                                 input logic [31:0] yl);
    exp_t e;
    logic [31:0] ytop;
    e.g  = (lvl < gl) ? lvl : gl;
    ytop = (lvl < yl) ? lvl : yl;
    e.y  = (ytop >= e.g) ? ytop - e.g : 32'd0;
    e.r  = lvl - e.g - e.y;
    return e;
  endfunction

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic align(input int unsigned p);
    for (int i = 0; i < 2 * DT && (ecnt % DT) != p; i++) tick_edge();
  endtask

  task automatic send(input logic signed [SW-1:0] s);
    sample       = s;
    sample_valid = 1'b1;
    tick_edge();
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b1;
    is_enable = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) tick_edge();
    n_checks++;
    if ({count_green, count_yellow, count_red} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", count_green, count_yellow, count_red);
    end
    n_checks++;
    if (counts_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b want 0", counts_valid);
    end
    reset_n = 1'b1;
    repeat (2) tick_edge();
    n_checks++;
    if ({count_green, count_yellow, count_red, counts_valid} !== 97'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %0d/%0d/%0d v=%b want 0/0/0 v=0",
               count_green, count_yellow, count_red, counts_valid);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    align(6);
    sb.push_back(split(32'd30, green_limit, yellow_limit));
    repeat (4) send(16'sd16384);
    repeat (2) tick_edge();
    n_checks++;
    if (counts_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_valid: got %b at N+2 want 0", counts_valid);
    end
    tick_edge();
    e = sb.pop_front();
    n_checks++;
    if (counts_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_valid: got %b at N+3 want 1", counts_valid);
    end
    n_checks++;
    if ({count_green, count_yellow, count_red} !== {e.g, e.y, e.r}) begin
      n_fail++;
      $display("FAIL basic_counts: got %0d/%0d/%0d want %0d/%0d/%0d",
               count_green, count_yellow, count_red, e.g, e.y, e.r);
    end
    tick_edge();
    n_checks++;
    if (counts_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_single_pulse: got %b at N+4 want 0", counts_valid);
    end
  endtask

  task automatic test_most_negative();
    exp_t e;
    align(6);
    sb.push_back(split(32'd59, green_limit, yellow_limit));
    send(16'sd16384);
    send(-16'sd32768);
    send(16'sd100);
    send(-16'sd5);
    repeat (3) tick_edge();
    e = sb.pop_front();
    n_checks++;
    if (counts_valid !== 1'b1 || {count_green, count_yellow, count_red} !== {e.g, e.y, e.r}) begin
      n_fail++;
      $display("FAIL most_negative: got %0d/%0d/%0d v=%b want %0d/%0d/%0d v=1",
               count_green, count_yellow, count_red, counts_valid, e.g, e.y, e.r);
    end
  endtask

  task automatic test_decay();
    for (int l = 58; l >= 0; l--) sb.push_back(split(32'(l), green_limit, yellow_limit));
    fork
      begin
        repeat (4 * WIN) send(16'sd0);
      end
      begin
        exp_t e;
        int   w;
        int   extra;
        for (int i = 0; i < 59; i++) begin
          w = 0;
          do begin
            tick_edge();
            w++;
          end while (!counts_valid && w < 20);
          e = sb.pop_front();
          n_checks++;
          if (counts_valid !== 1'b1 || {count_green, count_yellow, count_red} !== {e.g, e.y, e.r}) begin
            n_fail++;
            $display("FAIL decay_step%0d: got %0d/%0d/%0d v=%b want %0d/%0d/%0d v=1",
                     i, count_green, count_yellow, count_red, counts_valid, e.g, e.y, e.r);
          end
          if (i > 0) begin
            n_checks++;
            if (w != DT) begin
              n_fail++;
              $display("FAIL decay_period%0d: got %0d cycles want %0d", i, w, DT);
            end
          end
        end
        extra = 0;
        repeat (40) begin
          tick_edge();
          if (counts_valid) extra++;
        end
        n_checks++;
        if (extra != 0 || {count_green, count_yellow, count_red} !== 96'd0) begin
          n_fail++;
          $display("FAIL decay_hold_zero: got %0d pulses, counts %0d/%0d/%0d want 0 pulses, 0/0/0",
                   extra, count_green, count_yellow, count_red);
        end
      end
    join
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic signed [SW-1:0] vals [3];
    vals[0] = 16'sd13654;
    vals[1] = 16'sd10923;
    vals[2] = 16'sd16384;
    sb.push_back(split(32'd25, green_limit, yellow_limit));
    sb.push_back(split(32'd24, green_limit, yellow_limit));
    sb.push_back(split(32'd30, green_limit, yellow_limit));
    align(6);
    for (int k = 0; k < 15; k++) begin
      if (k < 12) send(vals[k / 4]);
      else        tick_edge();
      if (k == 6 || k == 10 || k == 14) begin
        e = sb.pop_front();
        n_checks++;
        if (counts_valid !== 1'b1 || {count_green, count_yellow, count_red} !== {e.g, e.y, e.r}) begin
          n_fail++;
          $display("FAIL back_to_back_k%0d: got %0d/%0d/%0d v=%b want %0d/%0d/%0d v=1",
                   k, count_green, count_yellow, count_red, counts_valid, e.g, e.y, e.r);
        end
      end
    end
  endtask

  task automatic test_inverted_limits();
    exp_t e;
    yellow_limit = 32'd30;
    align(6);
    sb.push_back(split(32'd45, green_limit, yellow_limit));
    repeat (4) send(16'sd24576);
    repeat (3) tick_edge();
    e = sb.pop_front();
    n_checks++;
    if (counts_valid !== 1'b1 || {count_green, count_yellow, count_red} !== {e.g, e.y, e.r}) begin
      n_fail++;
      $display("FAIL inverted_limits: got %0d/%0d/%0d v=%b want %0d/%0d/%0d v=1",
               count_green, count_yellow, count_red, counts_valid, e.g, e.y, e.r);
    end
    n_checks++;
    if (count_green + count_yellow + count_red !== 32'd45) begin
      n_fail++;
      $display("FAIL inverted_sum: got %0d want 45", count_green + count_yellow + count_red);
    end
    yellow_limit = 32'd50;
  endtask

  task automatic test_disable();
    exp_t e;
    int   nonzero;
    repeat (2) send(16'sd16384);
    is_enable    = 1'b0;
    sample       = -16'sd32768;
    sample_valid = 1'b1;
    repeat (2) tick_edge();
    n_checks++;
    if (counts_valid !== 1'b1 || {count_green, count_yellow, count_red} !== 96'd0) begin
      n_fail++;
      $display("FAIL disable_zero: got %0d/%0d/%0d v=%b want 0/0/0 v=1",
               count_green, count_yellow, count_red, counts_valid);
    end
    tick_edge();
    n_checks++;
    if (counts_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_quiet: got %b want 0", counts_valid);
    end
    sample_valid = 1'b0;
    is_enable    = 1'b1;
    repeat (3) send(16'sd16384);
    nonzero = 0;
    repeat (6) begin
      tick_edge();
      if ({count_green, count_yellow, count_red} !== 96'd0 || counts_valid) nonzero++;
    end
    n_checks++;
    if (nonzero != 0) begin
      n_fail++;
      $display("FAIL reenable_partial: got %0d active cycles want 0", nonzero);
    end
    sb.push_back(split(32'd30, green_limit, yellow_limit));
    send(16'sd16384);
    repeat (3) tick_edge();
    e = sb.pop_front();
    n_checks++;
    if (counts_valid !== 1'b1 || {count_green, count_yellow, count_red} !== {e.g, e.y, e.r}) begin
      n_fail++;
      $display("FAIL reenable_window: got %0d/%0d/%0d v=%b want %0d/%0d/%0d v=1",
               count_green, count_yellow, count_red, counts_valid, e.g, e.y, e.r);
    end
  endtask

  task automatic test_reset_mid();
    int nonzero;
    repeat (2) send(16'sd16384);
    #3 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({count_green, count_yellow, count_red, counts_valid} !== 97'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %0d/%0d/%0d v=%b want 0/0/0 v=0",
               count_green, count_yellow, count_red, counts_valid);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) send(16'sd16384);
    nonzero = 0;
    repeat (6) begin
      tick_edge();
      if ({count_green, count_yellow, count_red} !== 96'd0 || counts_valid) nonzero++;
    end
    n_checks++;
    if (nonzero != 0) begin
      n_fail++;
      $display("FAIL reset_window_abort: got %0d active cycles want 0", nonzero);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_most_negative();
    test_decay();
    test_back_to_back();
    test_inverted_limits();
    test_disable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
